fifo_rd_streamer: RTL

- Read-side engine for the team's synchronous FIFO (16-bit, depth 8).
- Drives the FIFO's rd_en from its empty flag and carries the registered data_out through a small skid buffer.
- Presents the data downstream as a valid/ready stream.
- Guarantees the FIFO is never read while empty, so the FIFO underflow flag stays low. Supports a flush that drains and discards FIFO contents.

---
 rtl/fifo_rd_pkg.sv | 24 ++
 rtl/fifo_rd_skid_buf.sv | 88 ++++++++
 rtl/fifo_rd_streamer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types for the FIFO read-side streamer: FSM encoding and the
// in-flight read tag that travels alongside the FIFO read latency.
package fifo_rd_pkg;

  localparam int STATE_W        = 2;
  localparam int MAX_RD_LATENCY = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } rd_state_e;

  typedef struct packed {
    logic valid;
    logic discard;
  } inflight_tag_t;

  // A tag delivers data into the skid buffer only if it was not marked for discard.
  function automatic logic tag_delivers(input inflight_tag_t tag);
    return tag.valid & ~tag.discard;
  endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Circular skid buffer between the FIFO read port and the output stream.
// Count runs 0..SKID_DEPTH; head entry is presented whenever count is non-zero.
// Clear empties the buffer (pointers and count) without touching storage.
module fifo_rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int SKID_DEPTH = 2
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              clear,
  input  logic                              push,
  input  logic [DATA_WIDTH-1:0]             push_data,
  input  logic                              pop,
  output logic [$clog2(SKID_DEPTH+1)-1:0]   count,
  output logic [DATA_WIDTH-1:0]             head_data
);

  localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CNT_W = $clog2(SKID_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [SKID_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  // Pointer advance with wrap at SKID_DEPTH (depth need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(SKID_DEPTH - 1)) begin
      return '0;
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  // Next-state for storage, pointers and occupancy count.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    pop_ok_s  = pop && (count_q != '0);
    push_ok_s = push && ((count_q != CNT_W'(SKID_DEPTH)) || pop_ok_s);
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok_s) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
    end
  end

  // Buffer state registers; storage is zeroed so the head reads 0 out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_rd_streamer.sv
// Read-side engine for the synchronous FIFO: issues fifo_rd_en only when
// the FIFO is non-empty and the skid buffer has credit, tracks reads in
// flight across the FIFO read latency, and presents a valid/ready stream.
// Flush drains and discards the FIFO and anything already in flight.
// Optional feature macro FIFO_RD_BEATCNT_EN adds the beat_count output.
module fifo_rd_streamer
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int RD_LATENCY = 1,
  parameter int SKID_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  flush_req,
  output logic                  flush_done,
  output logic                  busy
`ifdef FIFO_RD_BEATCNT_EN
  ,
  output logic [15:0]           beat_count
`endif
);

  localparam int CNT_W = $clog2(SKID_DEPTH + 1);
  localparam int OCC_W = CNT_W + 2;

  rd_state_e                       state_q, state_d;
  inflight_tag_t [RD_LATENCY-1:0]  tag_q, tag_d;
  logic [CNT_W-1:0]                skid_count_s;
  logic [DATA_WIDTH-1:0]           skid_head_s;
  logic [OCC_W-1:0]                inflight_cnt_s;
  logic [OCC_W-1:0]                occ_s;
  logic                            inflight_any_s;
  logic                            pop_s;
  logic                            push_s;
  logic                            flushing_s;
  logic                            rd_en_s;
  logic                            flush_done_s;

  // Count reads still travelling through the FIFO read latency.
  always_comb begin
    inflight_cnt_s = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight_cnt_s = inflight_cnt_s + OCC_W'(tag_q[i].valid);
    end
    inflight_any_s = (inflight_cnt_s != '0);
  end

  // FSM next state; flush takes priority over starting or continuing a stream.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d = FLUSH;
        end else if (!fifo_empty) begin
          state_d = STREAM;
        end else begin
          state_d = IDLE;
        end
      end
      STREAM: begin
        if (flush_req) begin
          state_d = FLUSH;
        end else if (fifo_empty && (skid_count_s == '0) && !inflight_any_s) begin
          state_d = IDLE;
        end else begin
          state_d = STREAM;
        end
      end
      FLUSH: begin
        if (fifo_empty && !inflight_any_s) begin
          state_d = IDLE;
        end else begin
          state_d = FLUSH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read credit: a read is allowed only if everything already owed to the
  // skid buffer, less the beat leaving this cycle, still leaves a free slot.
  always_comb begin
    pop_s        = m_valid && m_ready;
    occ_s        = OCC_W'(skid_count_s) + inflight_cnt_s;
    flushing_s   = (state_d == FLUSH);
    flush_done_s = (state_q == FLUSH) && fifo_empty && !inflight_any_s;
    case (state_q)
      STREAM: begin
        rd_en_s = !fifo_empty && (occ_s < (OCC_W'(SKID_DEPTH) + OCC_W'(pop_s)));
      end
      FLUSH: begin
        rd_en_s = !fifo_empty;
      end
      default: begin
        rd_en_s = 1'b0;
      end
    endcase
  end

  // Shift the in-flight tags; anything issued or still in flight once a
  // flush is underway is marked so its data is dropped on arrival.
  always_comb begin
    tag_d            = tag_q;
    tag_d[0].valid   = rd_en_s;
    tag_d[0].discard = rd_en_s && flushing_s;
    for (int i = 1; i < RD_LATENCY; i++) begin
      tag_d[i].valid   = tag_q[i-1].valid;
      tag_d[i].discard = tag_q[i-1].discard || flushing_s;
    end
    push_s = tag_delivers(tag_q[RD_LATENCY-1]) && !flushing_s;
  end

  // FSM state and in-flight pipeline registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
    end
  end

  fifo_rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .SKID_DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (flushing_s),
    .push       (push_s),
    .push_data  (fifo_data_out),
    .pop        (pop_s),
    .count      (skid_count_s),
    .head_data  (skid_head_s)
  );

`ifdef FIFO_RD_BEATCNT_EN
  logic [15:0] beat_count_q, beat_count_d;

  // Accepted-beat counter; restarts from zero when a flush completes.
  always_comb begin
    if (flush_done_s) begin
      beat_count_d = 16'd0;
    end else if (pop_s) begin
      beat_count_d = beat_count_q + 16'd1;
    end else begin
      beat_count_d = beat_count_q;
    end
  end

  // Beat counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_count_q <= 16'd0;
    end else begin
      beat_count_q <= beat_count_d;
    end
  end

  assign beat_count = beat_count_q;
`endif

  assign fifo_rd_en = rd_en_s;
  assign m_valid    = (skid_count_s != '0);
  assign m_data     = skid_head_s;
  assign flush_done = flush_done_s;
  assign busy       = (state_q != IDLE);

endmodule
